// File: rtl/hzrd_pkg.sv
// Shared definitions for the hazard scoreboard: RV32 major opcodes,
// source-operand usage classes and the variable-latency (LAT_LONG) encoding.
package hzrd_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // Default latency geometry; LAT_LONG is the all-ones latency code
    // meaning "completes later via the writeback port".
    localparam int unsigned DEF_MAX_LAT = 6;
    localparam int unsigned DEF_LAT_W   = $clog2(DEF_MAX_LAT + 2);
    localparam int unsigned LAT_LONG    = (32'd1 << DEF_LAT_W) - 32'd1;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RS1  = 2'd1,
        SRC_BOTH = 2'd2
    } src_use_e;

    // LAT_LONG code for an arbitrary latency field width
    function automatic int unsigned lat_long(input int unsigned lat_w);
        return (32'd1 << lat_w) - 32'd1;
    endfunction

    // Which source registers an instruction actually reads
    function automatic src_use_e decode_src(input logic [6:0] op);
        case (op)
            OP_BRANCH, OP_STORE, OP_RTYPE: return SRC_BOTH;
            OP_JALR, OP_LOAD, OP_IMM:      return SRC_RS1;
            default:                       return SRC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hzrd_reg_cnt.sv
// Per-register result-latency counter: load on issue, count down to zero,
// or hold at LAT_LONG until the matching writeback clears it.
module hzrd_reg_cnt
    import hzrd_pkg::*;
#(
    parameter int unsigned LAT_W = 3
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             wb_hit,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] LONG = LAT_W'(lat_long(LAT_W));

    // Issue has priority over completion; LAT_LONG holds until its writeback
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt == LONG) begin
            if (wb_hit) begin
                cnt <= '0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-busy scoreboard for an in-order pipeline: tracks result latency
// per architectural register and stalls IF/ID when a consumer reads a
// register whose result is not yet forwardable.
// Optional: define HZRD_PERF_CNT_EN to add the stall_cnt performance counter.
module hazard_scoreboard
    import hzrd_pkg::*;
#(
    parameter  int unsigned NUM_REGS = 32,
    parameter  int unsigned MAX_LAT  = 6,
    parameter  int unsigned CNT_W    = 32,
    localparam int unsigned RA_W     = $clog2(NUM_REGS),
    localparam int unsigned LAT_W    = $clog2(MAX_LAT + 2)
) (
    input  logic                CLK,
    input  logic                RSTn,
    input  logic [6:0]          OP,
    input  logic [RA_W-1:0]     IF_ID_RS1,
    input  logic [RA_W-1:0]     IF_ID_RS2,
    input  logic                iss_valid,
    input  logic [RA_W-1:0]     iss_rd,
    input  logic                iss_wr,
    input  logic [LAT_W-1:0]    iss_lat,
    input  logic                wb_valid,
    input  logic [RA_W-1:0]     wb_rd,
    input  logic                BrFlush,
    output logic                PCWrite,
    output logic                IF_ID_Write,
    output logic                ID_EX_CtrlSrc,
    output logic [NUM_REGS-1:0] busy_vec
`ifdef HZRD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    localparam logic [LAT_W-1:0] LONG  = LAT_W'(lat_long(LAT_W));
    localparam logic [LAT_W-1:0] MAX_V = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0] cnt [NUM_REGS];
    src_use_e         src_use;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;
    logic             accept;
    logic [LAT_W-1:0] load_val;

    // Source usage and hazard detection straight from the registered counters
    always_comb begin
        src_use  = decode_src(OP);
        uses_rs1 = (src_use != SRC_NONE);
        uses_rs2 = (src_use == SRC_BOTH);
        hazard   = (uses_rs1 && (cnt[IF_ID_RS1] != '0)) ||
                   (uses_rs2 && (cnt[IF_ID_RS2] != '0));
    end

    // Issue acceptance and latency saturation (LAT_LONG passes through)
    always_comb begin
        accept = iss_valid && !hazard && !BrFlush && iss_wr && (iss_rd != '0);
        if ((iss_lat != LONG) && (iss_lat > MAX_V)) begin
            load_val = MAX_V;
        end else begin
            load_val = iss_lat;
        end
    end

    // Pipeline control: reset forces a full hold, a flush always advances
    always_comb begin
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_CtrlSrc = 1'b1;
        if (!RSTn) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_CtrlSrc = 1'b0;
        end else if (BrFlush) begin
            ID_EX_CtrlSrc = 1'b0;
        end else if (hazard) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_CtrlSrc = 1'b0;
        end
    end

    // x0 is hardwired and never becomes busy
    assign cnt[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        hzrd_reg_cnt #(
            .LAT_W(LAT_W)
        ) u_cnt (
            .CLK     (CLK),
            .RSTn    (RSTn),
            .load    (accept && (iss_rd == RA_W'(r))),
            .load_val(load_val),
            .wb_hit  (wb_valid && (wb_rd == RA_W'(r))),
            .cnt     (cnt[r])
        );
    end

    // Busy flags: any non-zero counter
    always_comb begin
        busy_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

`ifdef HZRD_PERF_CNT_EN
    // Count genuine stall cycles (flush-overlapped hazards excluded), saturating
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            stall_cnt <= '0;
        end else if (hazard && !BrFlush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: table of directed cycles with hand-derived
// control expectations, a behavioural register-latency model for busy_vec,
// then constrained-random cycles checked entirely against the model.
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int MAX_LAT  = 6;
    localparam int LAT_LG   = 7;

    localparam logic [6:0] O_BR   = 7'b1100011;
    localparam logic [6:0] O_ST   = 7'b0100011;
    localparam logic [6:0] O_R    = 7'b0110011;
    localparam logic [6:0] O_JALR = 7'b1100111;
    localparam logic [6:0] O_LD   = 7'b0000011;
    localparam logic [6:0] O_IMM  = 7'b0010011;
    localparam logic [6:0] O_LUI  = 7'b0110111;
    localparam logic [6:0] O_JAL  = 7'b1101111;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [6:0]  OP = O_LUI;
    logic [4:0]  IF_ID_RS1 = '0;
    logic [4:0]  IF_ID_RS2 = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_wr = 1'b0;
    logic [2:0]  iss_lat = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        BrFlush = 1'b0;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        ID_EX_CtrlSrc;
    logic [31:0] busy_vec;
`ifdef HZRD_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_scoreboard #(
        .NUM_REGS(32),
        .MAX_LAT (6),
        .CNT_W   (32)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .OP           (OP),
        .IF_ID_RS1    (IF_ID_RS1),
        .IF_ID_RS2    (IF_ID_RS2),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_wr       (iss_wr),
        .iss_lat      (iss_lat),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .BrFlush      (BrFlush),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .ID_EX_CtrlSrc(ID_EX_CtrlSrc),
        .busy_vec     (busy_vec)
`ifdef HZRD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         rstn;
        logic [6:0] op;
        int         rs1;
        int         rs2;
        bit         iv;
        int         rd;
        bit         wr;
        int         lat;
        bit         wbv;
        int         wbrd;
        bit         fl;
        logic [2:0] exp;   // {PCWrite, IF_ID_Write, ID_EX_CtrlSrc}
    } vec_t;

    typedef struct {
        int          id;
        logic [2:0]  ctrl;
        logic [31:0] busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   mcnt[NUM_REGS];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit rstn, logic [6:0] op, int rs1, int rs2, bit iv, int rd,
                                bit wr, int lat, bit wbv, int wbrd, bit fl, logic [2:0] exp);
        vec_t v;
        v.rstn = rstn; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.iv = iv; v.rd = rd;
        v.wr = wr; v.lat = lat; v.wbv = wbv; v.wbrd = wbrd; v.fl = fl; v.exp = exp;
        return v;
    endfunction

    function automatic bit model_hazard(vec_t v);
        bit u1 = 0;
        bit u2 = 0;
        case (v.op)
            O_BR, O_ST, O_R:     begin u1 = 1; u2 = 1; end
            O_JALR, O_LD, O_IMM: u1 = 1;
            default:             ;
        endcase
        return (u1 && mcnt[v.rs1] != 0) || (u2 && mcnt[v.rs2] != 0);
    endfunction

    function automatic logic [2:0] model_ctrl(vec_t v);
        if (!v.rstn) return 3'b000;
        if (v.fl) return 3'b110;
        if (model_hazard(v)) return 3'b000;
        return 3'b111;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int r = 0; r < NUM_REGS; r++) b[r] = (mcnt[r] != 0);
        return b;
    endfunction

    task automatic model_step(vec_t v);
        int nxt[NUM_REGS];
        bit acc = v.iv && !model_hazard(v) && !v.fl && v.wr && v.rd != 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (!v.rstn || r == 0) nxt[r] = 0;
            else if (acc && v.rd == r) nxt[r] = (v.lat == LAT_LG) ? LAT_LG :
                                                (v.lat > MAX_LAT) ? MAX_LAT : v.lat;
            else if (mcnt[r] == LAT_LG) nxt[r] = (v.wbv && v.wbrd == r) ? 0 : LAT_LG;
            else if (mcnt[r] > 0) nxt[r] = mcnt[r] - 1;
            else nxt[r] = 0;
        end
        for (int r = 0; r < NUM_REGS; r++) mcnt[r] = nxt[r];
    endtask

    task automatic check_outputs();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sbq.pop_front();
        checks++;
        if ({PCWrite, IF_ID_Write, ID_EX_CtrlSrc} !== e.ctrl) begin
            errors++;
            $display("FAIL ctrl[%0d]: got %b expected %b", e.id,
                     {PCWrite, IF_ID_Write, ID_EX_CtrlSrc}, e.ctrl);
        end
        checks++;
        if (busy_vec !== e.busy) begin
            errors++;
            $display("FAIL busy_vec[%0d]: got %h expected %h", e.id, busy_vec, e.busy);
        end
    endtask

    task automatic run_cycle(input vec_t v, input int id, input bit use_tbl);
        exp_t e;
        RSTn = v.rstn; OP = v.op;
        IF_ID_RS1 = 5'(v.rs1); IF_ID_RS2 = 5'(v.rs2);
        iss_valid = v.iv; iss_rd = 5'(v.rd); iss_wr = v.wr; iss_lat = 3'(v.lat);
        wb_valid = v.wbv; wb_rd = 5'(v.wbrd); BrFlush = v.fl;
        #2;
        e.id   = id;
        e.ctrl = use_tbl ? v.exp : model_ctrl(v);
        e.busy = model_busy();
        sbq.push_back(e);
        check_outputs();
        model_step(v);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        for (int r = 0; r < NUM_REGS; r++) mcnt[r] = 0;

        // load-use, long latency, flush, x0, reset, latency corners, JALR
        tbl.push_back(mk(0, O_LUI, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_LD,  1, 0,  1, 5, 1, 1,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_R,   5, 2,  1, 6, 1, 2,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_R,   5, 2,  1, 6, 1, 2,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_IMM, 3, 0,  0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 7, 1, 7,  0, 0, 0, 3'b111));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1, O_IMM, 7, 0, 1, 8, 1, 1, (i == 1), 3, 0, 3'b000));
        tbl.push_back(mk(1, O_IMM, 7, 0,  1, 8, 1, 1,  1, 7, 0, 3'b000));
        tbl.push_back(mk(1, O_IMM, 7, 0,  1, 8, 1, 1,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 5, 1, 3,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_R,   5, 0,  1, 9, 1, 4,  0, 0, 1, 3'b110));
        tbl.push_back(mk(1, O_BR,  9, 5,  0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_BR,  9, 0,  0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 0, 1, 3,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_BR,  0, 0,  0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 9, 1, 7,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_IMM, 9, 0,  0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(0, O_IMM, 9, 0,  0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_IMM, 9, 0,  0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  0, 0, 0, 0,  1, 9, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 10, 1, 6, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  0, 0, 0, 0,  1, 10, 0, 3'b111));
        tbl.push_back(mk(1, O_JAL, 10, 10, 0, 0, 0, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_ST,  0, 10, 0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 11, 1, 7, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 11, 1, 2, 1, 11, 0, 3'b111));
        tbl.push_back(mk(1, O_IMM, 11, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_IMM, 11, 0, 0, 0, 0, 0,  0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_IMM, 11, 0, 0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 12, 1, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_R,   12, 12, 0, 0, 0, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 13, 0, 5, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_R,   0, 13, 0, 0, 0, 0,  0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_LUI, 0, 0,  1, 14, 1, 2, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_JALR, 0, 14, 0, 0, 0, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mk(1, O_JALR, 14, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(mk(1, O_JALR, 14, 0, 0, 0, 0, 0, 0, 0, 0, 3'b111));

        // Reset for two edges before any checking
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        foreach (tbl[i]) run_cycle(tbl[i], i, 1'b1);

        // Random traffic on a small register window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [8] = '{O_BR, O_ST, O_R, O_JALR, O_LD, O_IMM, O_LUI, O_JAL};
            rv = mk(($urandom_range(0, 49) != 0), ops[$urandom_range(0, 7)],
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1), $urandom_range(0, 7), ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 7),
                    ($urandom_range(0, 9) == 0), 3'b000);
            run_cycle(rv, 1000 + i, 1'b0);
        end

`ifdef HZRD_PERF_CNT_EN
        // Three real stalls plus one flush-overlapped stall count as three
        run_cycle(mk(0, O_LUI, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000), 2000, 1'b1);
        run_cycle(mk(1, O_LUI, 0, 0, 1, 5, 1, 7, 0, 0, 0, 3'b111), 2001, 1'b1);
        for (int i = 0; i < 3; i++)
            run_cycle(mk(1, O_IMM, 5, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000), 2002 + i, 1'b1);
        run_cycle(mk(1, O_IMM, 5, 0, 0, 0, 0, 0, 0, 0, 1, 3'b110), 2005, 1'b1);
        checks++;
        if (stall_cnt !== 32'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected 3", stall_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
